// File: rtl/rx_frame_collect_pkg.sv
// System-wide port/frame parameters (the generate_parameter.vh set) shared by the
// rx_frame_collect slice, plus the per-source context state type.
package rx_frame_collect_pkg;

  localparam int WIDTH_SEL      = 3;
  localparam int PORT_NUB       = 8;
  localparam int DATA_WIDTH     = 16;
  localparam int WIDTH_LENGTH   = 4;
  localparam int WIDTH_CRC      = 4;
  localparam int WIDTH_PRIORITY = 2;
  localparam int WIDTH_PORT     = WIDTH_SEL + DATA_WIDTH;

  // Length field position inside the header payload
  localparam int LEN_LSB = WIDTH_CRC + WIDTH_PRIORITY;
  localparam int LEN_MSB = LEN_LSB + WIDTH_LENGTH - 1;

  // Egress word: {sop, eop, src, payload}
  localparam int FIFO_W = 2 + WIDTH_SEL + DATA_WIDTH;

  typedef enum logic {
    CTX_IDLE = 1'b0,
    CTX_BUSY = 1'b1
  } ctx_state_t;

  function automatic logic [WIDTH_LENGTH-1:0] hdr_len(input logic [DATA_WIDTH-1:0] payload);
    return payload[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/rx_out_fifo.sv
// Synchronous show-ahead egress FIFO with occupancy output. A push while full is
// taken only when a pop happens in the same cycle.
module rx_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  // Storage is not reset; the consumer gates the read data with o_empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

endmodule

// File: rtl/rx_frame_collect.sv
// Per-source frame reassembly for one switch port: tags words with sop/eop and
// buffers them in rx_out_fifo. Optional macro RX_FRAME_CNT_EN adds frame_cnt.
module rx_frame_collect
  import rx_frame_collect_pkg::*;
#(
  parameter int NUB        = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [WIDTH_SEL-1:0]  nub_in,
  input  logic [WIDTH_PORT-1:0] data_in,
  output logic                  keep_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [WIDTH_SEL-1:0]  m_src,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [PORT_NUB-1:0]   done_out,
`ifdef RX_FRAME_CNT_EN
  output logic [31:0]           frame_cnt,
`endif
  output logic                  err_out
);

  localparam logic [WIDTH_SEL-1:0] NUB_SEL = WIDTH_SEL'(NUB);
  localparam int                   CW      = $clog2(FIFO_DEPTH) + 1;

  ctx_state_t              r_state     [PORT_NUB];
  ctx_state_t              w_state_nxt [PORT_NUB];
  logic [WIDTH_LENGTH-1:0] r_cnt       [PORT_NUB];
  logic [WIDTH_LENGTH-1:0] w_cnt_nxt   [PORT_NUB];

  logic [WIDTH_SEL-1:0]    w_dest;
  logic [DATA_WIDTH-1:0]   w_payload;
  logic [WIDTH_LENGTH-1:0] w_len;
  logic                    w_match;
  logic                    w_sop;
  logic                    w_eop;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_full;
  logic [CW-1:0]           w_count;
  logic [CW-1:0]           w_occ_nxt;
  logic [FIFO_W-1:0]       w_rdata;
  logic                    w_err_nxt;
  logic [PORT_NUB-1:0]     w_done_nxt;

  logic                    r_keep;
  logic                    r_err;
  logic [PORT_NUB-1:0]     r_done;

  assign {w_dest, w_payload} = data_in;
  assign w_len   = hdr_len(w_payload);
  assign w_match = valid_in && (w_dest == NUB_SEL);

  // Context next-state: headers open a frame, body words count it down.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sop       = 1'b0;
    w_eop       = 1'b0;
    if (w_match) begin
      if (r_state[nub_in] == CTX_IDLE) begin
        w_sop              = 1'b1;
        w_eop              = (w_len == '0);
        w_cnt_nxt[nub_in]  = w_len;
        w_state_nxt[nub_in] = w_eop ? CTX_IDLE : CTX_BUSY;
      end else begin
        w_eop             = (r_cnt[nub_in] == WIDTH_LENGTH'(1));
        w_cnt_nxt[nub_in] = r_cnt[nub_in] - WIDTH_LENGTH'(1);
        if (w_eop) w_state_nxt[nub_in] = CTX_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORT_NUB; i++) begin
        r_state[i] <= CTX_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Egress handshake: a word moves when m_valid and m_ready are both high in the
  // same cycle; m_* hold while m_valid is high and m_ready is low.
  assign w_pop  = m_ready && !w_empty;
  assign w_push = w_match && (!w_full || w_pop);

  // Framing advances even when the FIFO drops the word, so later words stay aligned.
  always_comb begin
    w_done_nxt = '0;
    w_err_nxt  = (valid_in && !w_match) || (w_match && !w_push);
    if (w_match && w_eop) w_done_nxt[nub_in] = 1'b1;
  end

  assign w_occ_nxt = w_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keep <= 1'b0;
      r_err  <= 1'b0;
      r_done <= '0;
    end else begin
      r_keep <= (w_occ_nxt >= CW'(FIFO_DEPTH - 2));
      r_err  <= w_err_nxt;
      r_done <= w_done_nxt;
    end
  end

  rx_out_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({w_sop, w_eop, nub_in, w_payload}),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign m_valid = !w_empty;
  assign {m_sop, m_eop, m_src, m_data} = w_empty ? '0 : w_rdata;
  assign keep_out = r_keep;
  assign err_out  = r_err;
  assign done_out = r_done;

`ifdef RX_FRAME_CNT_EN
  logic [31:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_frame_cnt <= '0;
    else if (w_push && w_eop)  r_frame_cnt <= r_frame_cnt + 32'd1;
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_rx_frame_collect.sv
// Bench for rx_frame_collect (NUB=2, FIFO_DEPTH=16): directed scenarios plus
// random traffic, scored against a frame-level reference model.
module tb_rx_frame_collect;
  import rx_frame_collect_pkg::*;

  localparam int NUB   = 2;
  localparam int DEPTH = 16;
  localparam int W     = FIFO_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  valid_in = 1'b0;
  logic [WIDTH_SEL-1:0]  nub_in = '0;
  logic [WIDTH_PORT-1:0] data_in = '0;
  logic                  m_ready = 1'b0;
  logic                  keep_out;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic [WIDTH_SEL-1:0]  m_src;
  logic                  m_sop;
  logic                  m_eop;
  logic [PORT_NUB-1:0]   done_out;
  logic                  err_out;
`ifdef RX_FRAME_CNT_EN
  logic [31:0]           frame_cnt;
`endif

  rx_frame_collect #(.NUB(NUB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .nub_in   (nub_in),
    .data_in  (data_in),
    .keep_out (keep_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_src    (m_src),
    .m_sop    (m_sop),
    .m_eop    (m_eop),
    .done_out (done_out),
`ifdef RX_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .err_out  (err_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [W-1:0]        exp_q[$];
  int                  rem[PORT_NUB];
  logic                exp_err;
  logic                exp_keep;
  logic [PORT_NUB-1:0] exp_done;
  int unsigned         exp_fc;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < PORT_NUB; i++) rem[i] = 0;
    exp_err  = 1'b0;
    exp_keep = 1'b0;
    exp_done = '0;
    exp_fc   = 0;
  endtask

  // One clock edge of the frame rules applied to the inputs present at that edge.
  task automatic model_step();
    bit                    pop;
    bit                    push;
    bit                    sop;
    bit                    eop;
    int                    s;
    int                    len;
    logic [DATA_WIDTH-1:0] pl;
    pop      = m_ready && (exp_q.size() > 0);
    push     = 1'b0;
    sop      = 1'b0;
    eop      = 1'b0;
    exp_err  = 1'b0;
    exp_done = '0;
    s        = int'(nub_in);
    pl       = data_in[DATA_WIDTH-1:0];
    if (valid_in) begin
      if (int'(data_in[WIDTH_PORT-1 -: WIDTH_SEL]) != NUB) begin
        exp_err = 1'b1;
      end else begin
        if (rem[s] == 0) begin
          len    = int'(pl[LEN_MSB:LEN_LSB]);
          sop    = 1'b1;
          eop    = (len == 0);
          rem[s] = len;
        end else begin
          rem[s] = rem[s] - 1;
          eop    = (rem[s] == 0);
        end
        if (exp_q.size() < DEPTH || pop) push = 1'b1;
        else exp_err = 1'b1;
        if (eop) exp_done[s] = 1'b1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({sop, eop, WIDTH_SEL'(s), pl});
      if (eop) exp_fc++;
    end
    exp_keep = (exp_q.size() >= DEPTH - 2);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      n_tests++;
      if (m_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_valid t=%0t: got %b want %b", $time, m_valid, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        n_tests++;
        if ({m_sop, m_eop, m_src, m_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_word t=%0t: got %h want %h", $time, {m_sop, m_eop, m_src, m_data}, exp_q[0]);
        end
      end
      n_tests++;
      if (keep_out !== exp_keep) begin
        n_fail++;
        $display("FAIL sb_keep t=%0t: got %b want %b", $time, keep_out, exp_keep);
      end
      n_tests++;
      if (err_out !== exp_err) begin
        n_fail++;
        $display("FAIL sb_err t=%0t: got %b want %b", $time, err_out, exp_err);
      end
      n_tests++;
      if (done_out !== exp_done) begin
        n_fail++;
        $display("FAIL sb_done t=%0t: got %b want %b", $time, done_out, exp_done);
      end
`ifdef RX_FRAME_CNT_EN
      n_tests++;
      if (frame_cnt !== exp_fc) begin
        n_fail++;
        $display("FAIL sb_frame_cnt t=%0t: got %0d want %0d", $time, frame_cnt, exp_fc);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, advance the model at the edge, return 1 after it.
  task automatic cycle(input bit v, input int src, input int dest,
                       input logic [DATA_WIDTH-1:0] pl, input bit rdy);
    valid_in = v;
    nub_in   = WIDTH_SEL'(src);
    data_in  = {WIDTH_SEL'(dest), pl};
    m_ready  = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, '0, 1'b1);
  endtask

  function automatic logic [DATA_WIDTH-1:0] hdr(input int len);
    logic [DATA_WIDTH-1:0]   p;
    logic [WIDTH_LENGTH-1:0] l;
    p = DATA_WIDTH'($urandom);
    l = WIDTH_LENGTH'(len);
    p[LEN_MSB:LEN_LSB] = l;
    return p;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] body();
    return DATA_WIDTH'($urandom);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W+4+PORT_NUB-1:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {m_valid, m_sop, m_eop, keep_out, err_out, done_out, m_src, m_data};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    model_reset();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    n_tests++;
    if (m_valid !== 1'b0 || keep_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b keep=%b want 0 0", m_valid, keep_out);
    end
  endtask

  task automatic test_single_frame();
    cycle(1'b1, 1, NUB, hdr(3), 1'b1);
    n_tests++;
    if (m_valid !== 1'b1 || m_sop !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first: got valid=%b sop=%b want 1 1", m_valid, m_sop);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1, NUB, body(), 1'b1);
    n_tests++;
    if (done_out !== 8'b0000_0010) begin
      n_fail++;
      $display("FAIL single_done: got %b want 00000010", done_out);
    end
    n_tests++;
    if ({m_valid, m_sop, m_eop} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_last: got v/s/e=%b want 101", {m_valid, m_sop, m_eop});
    end
    idle(1);
    n_tests++;
    if (m_valid !== 1'b0 || done_out !== '0) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b done=%b want 0 0", m_valid, done_out);
    end
  endtask

  task automatic test_interleave();
    int srcs[5];
    int t0;
    int t3;
    srcs = '{0, 3, 0, 3, 0};
    t0 = -1;
    t3 = -1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      cycle(1'b1, 0, NUB, hdr(2), 1'b1);
      else if (i == 1) cycle(1'b1, 3, NUB, hdr(1), 1'b1);
      else             cycle(1'b1, srcs[i], NUB, body(), 1'b1);
      if (done_out[0] && t0 < 0) t0 = i;
      if (done_out[3] && t3 < 0) t3 = i;
    end
    idle(2);
    n_tests++;
    if (t3 != 3 || t0 != 4) begin
      n_fail++;
      $display("FAIL interleave_done_order: got t3=%0d t0=%0d want 3 4", t3, t0);
    end
  endtask

  task automatic test_zero_len();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 5, NUB, hdr(0), 1'b1);
      n_tests++;
      if ({m_valid, m_sop, m_eop, m_src} !== {3'b111, 3'd5} || done_out !== 8'h20) begin
        n_fail++;
        $display("FAIL zero_len_%0d: got vse=%b src=%0d done=%h want 111 5 20",
                 k, {m_valid, m_sop, m_eop}, m_src, done_out);
      end
    end
    idle(2);
  endtask

  task automatic test_bad_dest();
    cycle(1'b1, 4, 1, hdr(1), 1'b1);
    n_tests++;
    if (err_out !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_dest: got err=%b valid=%b want 1 0", err_out, m_valid);
    end
    cycle(1'b1, 4, NUB, hdr(1), 1'b1);
    n_tests++;
    if (m_sop !== 1'b1 || m_src !== 3'd4 || err_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_dest_next_hdr: got sop=%b src=%0d err=%b want 1 4 0", m_sop, m_src, err_out);
    end
    cycle(1'b1, 4, NUB, body(), 1'b1);
    n_tests++;
    if (m_eop !== 1'b1 || done_out !== 8'h10) begin
      n_fail++;
      $display("FAIL bad_dest_eop: got eop=%b done=%h want 1 10", m_eop, done_out);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 6, NUB, (k == 1) ? hdr(15) : body(), 1'b0);
      n_tests++;
      if (keep_out !== (k >= 14)) begin
        n_fail++;
        $display("FAIL bp_keep_push%0d: got %b want %b", k, keep_out, k >= 14);
      end
    end
    n_tests++;
    if (done_out !== 8'h40) begin
      n_fail++;
      $display("FAIL bp_done16: got %h want 40", done_out);
    end
    cycle(1'b1, 6, NUB, hdr(0), 1'b0);
    n_tests++;
    if ({err_out, keep_out, m_valid} !== 3'b111 || done_out !== 8'h40) begin
      n_fail++;
      $display("FAIL bp_drop17: got err/keep/valid=%b done=%h want 111 40",
               {err_out, keep_out, m_valid}, done_out);
    end
    cycle(1'b1, 6, NUB, hdr(0), 1'b1);
    n_tests++;
    if (err_out !== 1'b0 || done_out !== 8'h40) begin
      n_fail++;
      $display("FAIL bp_push_pop_full: got err=%b done=%h want 0 40", err_out, done_out);
    end
    idle(20);
    n_tests++;
    if (m_valid !== 1'b0 || keep_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%b keep=%b want 0 0", m_valid, keep_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [W+4+PORT_NUB-1:0] got;
    cycle(1'b1, 2, NUB, hdr(3), 1'b1);
    cycle(1'b1, 2, NUB, body(), 1'b1);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    got = {m_valid, m_sop, m_eop, keep_out, err_out, done_out, m_src, m_data};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want 0", got);
    end
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(1'b1, 2, NUB, hdr(1), 1'b1);
    n_tests++;
    if ({m_valid, m_sop, m_eop} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_mid_header: got v/s/e=%b want 110", {m_valid, m_sop, m_eop});
    end
    cycle(1'b1, 2, NUB, body(), 1'b1);
    n_tests++;
    if (m_eop !== 1'b1 || done_out !== 8'h04) begin
      n_fail++;
      $display("FAIL reset_mid_eop: got eop=%b done=%h want 1 04", m_eop, done_out);
    end
    idle(2);
  endtask

  task automatic test_random();
    bit                    v;
    bit                    rdy;
    int                    src;
    int                    dest;
    logic [DATA_WIDTH-1:0] pl;
    for (int i = 0; i < 800; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      src  = $urandom_range(0, PORT_NUB - 1);
      dest = ($urandom_range(0, 7) == 0) ? (NUB + $urandom_range(1, 7)) % 8 : NUB;
      pl   = DATA_WIDTH'($urandom);
      pl[LEN_MSB:LEN_LSB] = WIDTH_LENGTH'($urandom_range(0, 3));
      rdy  = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      cycle(v, src, dest, pl, rdy);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: got valid=%b want 0 after drain budget", m_valid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_interleave();
    test_zero_len();
    test_bad_dest();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_collect.md
RX_FRAME_COLLECT -- requirements
Module: rx_frame_collect

Interface
REQ-001 Parameter NUB, default 0: port number owned by this block; only words with destination field equal to NUB are accepted.
REQ-002 Parameter FIFO_DEPTH, default 16: output FIFO depth in words, power of two, at least 4.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_in  input  1  word valid from the switching chain.
REQ-006 nub_in  input  WIDTH_SEL  source port of the word.
REQ-007 data_in  input  WIDTH_PORT  {dest[WIDTH_SEL], payload[DATA_WIDTH]}.
REQ-008 keep_out  output  1  backpressure to the chain; upstream holds its stage while high.
REQ-009 m_valid / m_ready  output / input  1 / 1  egress handshake; a word transfers when both are high.
REQ-010 m_data  output  DATA_WIDTH  payload; m_src  output  WIDTH_SEL  source port.
REQ-011 m_sop / m_eop  output  1 / 1  first / last word of a frame.
REQ-012 done_out  output  PORT_NUB  one-cycle pulse on bit s when a frame from source s completes.
REQ-013 err_out  output  1  one-cycle pulse on a drop event.

Function
REQ-014 Per-source context s (0..PORT_NUB-1): state IDLE/BUSY plus remaining-word counter cnt[s], WIDTH_LENGTH bits.
REQ-015 Header field: L = payload[WIDTH_LENGTH+WIDTH_CRC+WIDTH_PRIORITY-1 : WIDTH_CRC+WIDTH_PRIORITY]; a frame is 1 header word plus L body words.
REQ-016 Accepted word (valid_in=1, dest==NUB) from source s with ctx IDLE: header; sop=1, cnt[s]<=L; if L==0 then eop=1 and ctx stays IDLE, else ctx<=BUSY.
REQ-017 Accepted word from source s with ctx BUSY: body; sop=0, cnt[s]<=cnt[s]-1; if cnt[s]==1 then eop=1 and ctx<=IDLE.
REQ-018 Words from different sources may interleave arbitrarily; each context advances independently; at most one word per cycle.
REQ-019 done_out[s] pulses exactly one cycle, in the cycle after the eop word of source s is accepted; other bits stay 0.
REQ-020 valid_in=1 with dest!=NUB: word dropped, no context change, err_out pulses the next cycle.
REQ-021 Accepted word with the FIFO full and no pop in the same cycle: word dropped, context still advances (framing preserved), err_out pulses the next cycle; done_out still pulses on eop.
REQ-022 Simultaneous push and pop with the FIFO full: push accepted.
REQ-023 Latency: an accepted word appears on m_* no earlier than the cycle after the push (registered FIFO, show-ahead output).
REQ-024 keep_out is registered: 1 when FIFO occupancy >= FIFO_DEPTH-2 after the current cycle's push/pop, else 0.
REQ-025 The m_* outputs hold stable while m_valid=1 and m_ready=0.

Reset
REQ-026 On reset: all contexts IDLE, all cnt 0, FIFO empty, and m_valid, m_sop, m_eop, keep_out, done_out, err_out all 0; m_data and m_src are 0.
REQ-027 Reset mid-frame discards partial frames; the next word from each source is treated as a header.

Configuration
REQ-028 Macro RX_FRAME_CNT_EN defined: add output frame_cnt[31:0], which counts eop words pushed into the FIFO, wraps at 2^32, and resets to 0.
REQ-029 Macro RX_FRAME_CNT_EN undefined: no frame_cnt port and no counter logic.

Structure
REQ-030 WIDTH_SEL, WIDTH_PORT, WIDTH_LENGTH, WIDTH_CRC, WIDTH_PRIORITY, PORT_NUB, DATA_WIDTH and the length-field offsets come from generate_parameter.vh; none are redefined locally.
REQ-031 Egress buffer is sub-module rx_out_fifo: synchronous, show-ahead, word = {sop, eop, src, payload}, with occupancy output.

Verification
REQ-032 NUB=2, source 1 sends header L=3 and then 3 body words back-to-back, m_ready=1 -> 4 words out; sop on word 1, eop on word 4; done_out=0b0010 one cycle after the last push.
REQ-033 Sources 0 and 3 interleave frames with L=2 and L=1 -> each stream is framed correctly; done_out[3] pulses before done_out[0].
REQ-034 Header with L=0 from source 5 -> single word with sop=1 and eop=1, done_out[5] pulse, context remains IDLE.
REQ-035 Word with dest=1 while NUB=2 -> no output, err_out pulse, and the following header from the same source is framed normally.
REQ-036 m_ready=0 with FIFO_DEPTH=16: keep_out rises after the 14th push; 17th push is dropped with err_out and done_out still pulses on eop; push plus pop at full is accepted.
REQ-037 Assert rst_n low mid-frame (cnt=2) -> all outputs 0; next word is treated as a header with sop=1.
